// File: rtl/mem_arb_pkg.sv
// Shared types for the unified IM/DM SRAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IM   = 2'd1,
        RESP_DM   = 2'd2
    } resp_port_e;

    // Sliced down to DATA_W/8 bits by the user; all ones means "no byte written".
    localparam logic [63:0] WEB_READ = '1;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data ports.
// Data wins by default; a starvation counter forces an instruction grant.
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                im_req,
    input  logic [ADDR_W-1:0]   im_addr,
    output logic                im_gnt,
    output logic                im_rvalid,
    output logic [DATA_W-1:0]   im_rdata,
    input  logic                dm_req,
    input  logic [DATA_W/8-1:0] dm_web,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                sram_cs,
    output logic                sram_oe,
    output logic [DATA_W/8-1:0] sram_web,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);

    localparam int               WEB_W   = DATA_W / 8;
    localparam logic [WEB_W-1:0] WEB_RD  = WEB_READ[WEB_W-1:0];
    localparam logic [3:0]       LIMIT   = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    resp_port_e resp_port_q, resp_port_d;
    logic       resp_rd_q, resp_rd_d;
    logic       im_win, dm_win;

    // Priority decision; nothing is granted while reset is held.
    always_comb begin
        im_win = 1'b0;
        dm_win = 1'b0;
        if (!rst) begin
            if (im_req && (starve_q == LIMIT)) im_win = 1'b1;
            else if (dm_req)                   dm_win = 1'b1;
            else if (im_req)                   im_win = 1'b1;
        end
    end

    always_comb begin
        sram_cs  = im_win | dm_win;
        sram_a   = '0;
        sram_web = WEB_RD;
        sram_di  = '0;
        if (dm_win) begin
            sram_a   = dm_addr;
            sram_web = dm_web;
            sram_di  = dm_wdata;
        end else if (im_win) begin
            sram_a   = im_addr;
        end

        resp_port_d = RESP_NONE;
        if (dm_win)      resp_port_d = RESP_DM;
        else if (im_win) resp_port_d = RESP_IM;
        resp_rd_d = im_win | (dm_win & (dm_web == WEB_RD));

        starve_d = 4'd0;
        if (im_req && !im_win)
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= 4'd0;
            resp_port_q <= RESP_NONE;
            resp_rd_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            resp_port_q <= resp_port_d;
            resp_rd_q   <= resp_rd_d;
        end
    end

    assign im_gnt    = im_win;
    assign dm_gnt    = dm_win;
    assign sram_oe   = resp_rd_q;
    assign im_rvalid = (resp_port_q == RESP_IM);
    assign dm_rvalid = (resp_port_q == RESP_DM);
    // Write acknowledges carry no data, so dm_rdata stays zero for them.
    assign im_rdata  = (im_rvalid && resp_rd_q) ? sram_do : '0;
    assign dm_rdata  = (dm_rvalid && resp_rd_q) ? sram_do : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM and reference memory.
module tb_sram_port_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int WW  = DW / 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          im_req = 1'b0, dm_req = 1'b0;
    logic [AW-1:0] im_addr = '0, dm_addr = '0;
    logic [WW-1:0] dm_web = '1;
    logic [DW-1:0] dm_wdata = '0;
    logic          im_gnt, im_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] im_rdata, dm_rdata;
    logic          sram_cs, sram_oe;
    logic [WW-1:0] sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_di;
    logic [DW-1:0] sram_do = '0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM macro
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (sram_cs) begin
            if (&sram_web) sram_do <= sram_mem[sram_a];
            else
                for (int b = 0; b < WW; b++)
                    if (!sram_web[b]) sram_mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
        end
    end

    typedef struct {
        int            cyc;
        bit            is_dm;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;
    int   im_gnt_cnt = 0, dm_gnt_cnt = 0, im_rv_cnt = 0, dm_rv_cnt = 0;
    int   waited = 0;
    bit   m_im = 0, m_dm = 0;
    logic [31:0]   gseq = '0;
    logic [DW-1:0] last_im_rdata = '0, last_dm_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr,
                         input logic [WW-1:0] dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        im_req = ir; im_addr = ia; dm_req = dr; dm_web = dw; dm_addr = da; dm_wdata = dd;
    endtask

    // One cycle: predict the grant from the arbitration rules, compare, queue the response.
    task automatic step();
        exp_t e;
        logic [AW-1:0] exp_a;
        @(negedge clk);
        m_im = 0; m_dm = 0;
        if (!rst) begin
            if (im_req && waited >= LIM) m_im = 1;
            else if (dm_req)             m_dm = 1;
            else if (im_req)             m_im = 1;
        end
        exp_a = m_dm ? dm_addr : (m_im ? im_addr : '0);
        check("im_gnt", im_gnt, m_im);
        check("dm_gnt", dm_gnt, m_dm);
        check("sram_cs", sram_cs, m_im | m_dm);
        check("sram_a", sram_a, exp_a);
        check("sram_web", sram_web, m_dm ? dm_web : {WW{1'b1}});
        check("sram_di", sram_di, m_dm ? dm_wdata : '0);
        if (im_gnt) im_gnt_cnt++;
        if (dm_gnt) dm_gnt_cnt++;
        gseq = {gseq[30:0], im_gnt};
        e.cyc = cyc;
        if (m_im) begin
            e.is_dm = 0; e.rd = 1; e.data = ref_mem[im_addr];
            exp_q.push_back(e);
        end else if (m_dm) begin
            e.is_dm = 1;
            e.rd = &dm_web;
            e.data = (&dm_web) ? ref_mem[dm_addr] : '0;
            exp_q.push_back(e);
            for (int b = 0; b < WW; b++)
                if (!dm_web[b]) ref_mem[dm_addr][b*8 +: 8] = dm_wdata[b*8 +: 8];
        end
        if (!rst && im_req && !m_im) waited = (waited + 1 > LIM) ? LIM : waited + 1;
        else waited = 0;
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc - 1) begin
                n_cmp++; n_err++;
                $display("FAIL lost_rvalid: got none expected response of cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (im_rvalid || dm_rvalid) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc - 1) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_rvalid: got im=%0b dm=%0b expected none (cycle %0d)",
                             im_rvalid, dm_rvalid, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rvalid_port", {im_rvalid, dm_rvalid}, e.is_dm ? 2'b01 : 2'b10);
                    check("sram_oe", sram_oe, e.rd);
                    if (e.is_dm) begin
                        check("dm_rdata", dm_rdata, e.data);
                        check("im_rdata_idle", im_rdata, 0);
                        dm_rv_cnt++;
                        last_dm_rdata = dm_rdata;
                    end else begin
                        check("im_rdata", im_rdata, e.data);
                        check("dm_rdata_idle", dm_rdata, 0);
                        im_rv_cnt++;
                        last_im_rdata = im_rdata;
                    end
                end
            end else begin
                check("sram_oe_idle", sram_oe, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = i * 32'h9E3779B1;
            ref_mem[i]  = i * 32'h9E3779B1;
        end
        sram_mem['h0010] = 32'h00000013;  ref_mem['h0010] = 32'h00000013;
        sram_mem['h2000] = 32'h11223344;  ref_mem['h2000] = 32'h11223344;

        // Reset state: grants suppressed even with requests high
        drive(1, 'h5, 1, '1, 'h6, 0);
        @(negedge clk);
        check("rst_im_gnt", im_gnt, 0);
        check("rst_dm_gnt", dm_gnt, 0);
        check("rst_sram_cs", sram_cs, 0);
        drive(0, 0, 0, '1, 0, 0);
        #1;
        check("rst_sram_web", sram_web, 4'hF);
        check("rst_sram_a", sram_a, 0);
        check("rst_sram_di", sram_di, 0);
        check("rst_rvalid", {im_rvalid, dm_rvalid, sram_oe}, 0);
        check("rst_rdata", {im_rdata, dm_rdata}, 0);
        @(posedge clk); #1;
        rst = 0;

        // Instruction fetch
        drive(1, 'h0010, 0, '1, 0, 0); step();
        drive(0, 0, 0, '1, 0, 0);      step();
        check("fetch_0010", last_im_rdata, 32'h00000013);

        // Partial write then readback
        drive(0, 0, 1, 4'b1100, 'h2000, 32'hAABBCCDD); step();
        drive(0, 0, 0, '1, 0, 0);                       step();
        drive(0, 0, 1, 4'b1111, 'h2000, 0);             step();
        drive(0, 0, 0, '1, 0, 0);                       step();
        check("partial_write", last_dm_rdata, 32'h1122CCDD);

        // Both requesting for 10 cycles
        gseq = '0;
        drive(1, 'h20, 1, '1, 'h30, 0);
        for (int i = 0; i < 10; i++) step();
        check("starve_seq", gseq[9:0], 10'b0000100001);
        drive(0, 0, 0, '1, 0, 0); step();

        // SIM_END write interleaved with continuous fetch
        im_gnt_cnt = 0; dm_gnt_cnt = 0; im_rv_cnt = 0; dm_rv_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            drive(1, AW'(i), (i % 3) != 2, '1, 'h3fff, 0);
            if ((i % 3) != 2) begin dm_web = 4'b0000; dm_wdata = 32'hFFFFFFFF; end
            step();
        end
        drive(0, 0, 1, '1, 'h3fff, 0); step();
        drive(0, 0, 0, '1, 0, 0);      step();
        check("sim_end_word", last_dm_rdata, 32'hFFFFFFFF);
        step();
        check("im_gnt_vs_rvalid", im_rv_cnt, im_gnt_cnt);
        check("dm_gnt_vs_rvalid", dm_rv_cnt, dm_gnt_cnt);

        // Reset in the cycle after a data read grant
        drive(0, 0, 1, '1, 'h40, 0); step();
        rst = 1;
        exp_q.delete();
        waited = 0;
        drive(1, 'h44, 0, '1, 0, 0);
        @(negedge clk);
        check("mid_rst_dm_rvalid", dm_rvalid, 0);
        check("mid_rst_oe", sram_oe, 0);
        check("mid_rst_im_gnt", im_gnt, 0);
        @(posedge clk); #1;
        rst = 0;
        step();
        check("post_rst_first_gnt", gseq[0], 1);
        gseq = '0;
        drive(1, 'h44, 1, '1, 'h48, 0);
        for (int i = 0; i < 5; i++) step();
        check("post_rst_starve", gseq[4:0], 5'b00001);
        drive(0, 0, 0, '1, 0, 0); step();

        // im dropped after 2 denials restarts the wait
        drive(1, 'h50, 1, '1, 'h60, 0);
        step(); step();
        drive(0, 0, 1, '1, 'h60, 0); step();
        gseq = '0;
        drive(1, 'h50, 1, '1, 'h60, 0);
        for (int i = 0; i < 5; i++) step();
        check("starve_restart", gseq[4:0], 5'b00001);
        drive(0, 0, 0, '1, 0, 0); step();

        // Randomized traffic with hold-until-grant requesters
        for (int i = 0; i < 400; i++) begin
            if (im_req && !m_im) begin
                if ($urandom_range(7) == 0) im_req = 0;
            end else begin
                im_req  = $urandom_range(1);
                im_addr = AW'($urandom_range(63));
            end
            if (dm_req && !m_dm) begin
                if ($urandom_range(7) == 0) dm_req = 0;
            end else begin
                dm_req   = $urandom_range(1);
                dm_addr  = AW'($urandom_range(63));
                dm_wdata = $urandom;
                dm_web   = ($urandom_range(1) == 0) ? 4'hF : WW'($urandom_range(14));
            end
            step();
        end
        drive(0, 0, 0, '1, 0, 0);
        step(); step();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares one synchronous single-port SRAM macro (SRAM_wrapper style: CS, OE, byte-wise active-low WEB, word address) between the CPU instruction-fetch port and data-memory port. It enables a unified-memory build of `top`, where the IM and DM images occupy one array. Data accesses win by default; a starvation guard forces an instruction grant after a bounded wait. Read data returns one cycle after grant, tagged to the winning port.

## Interface
- ADDR_W, 14, word-address width (16K words, matches SIM_END 'h3fff)
- DATA_W, 32, data width; WEB width is DATA_W/8
- STARVE_LIMIT, 4, consecutive denied instruction-request cycles before instruction priority is forced (1..15)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- im_req  in  1  instruction read request
- im_addr  in  ADDR_W  instruction word address
- im_gnt  out  1  instruction request accepted this cycle (combinational)
- im_rvalid  out  1  instruction read data valid
- im_rdata  out  DATA_W  instruction read data
- dm_req  in  1  data request
- dm_web  in  DATA_W/8  byte write enables, active-low; all-ones = read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  data read data valid / write acknowledge
- dm_rdata  out  DATA_W  data read data
- sram_cs  out  1  chip select
- sram_oe  out  1  output enable
- sram_web  out  DATA_W/8  byte write enables, active-low
- sram_a  out  ADDR_W  address
- sram_di  out  DATA_W  write data
- sram_do  in  DATA_W  read data from macro

## Operation
- At most one grant per cycle. Grant rule, in order:
  - starve_cnt == STARVE_LIMIT and im_req → im wins.
  - Else dm_req → dm wins.
  - Else im_req → im wins.
  - Else no grant.
- On grant: sram_cs=1; sram_a=winner addr. For dm, sram_web=dm_web and sram_di=dm_wdata. For im, sram_web=all ones and sram_di=0. With no grant: sram_cs=0, sram_web=all ones, sram_a=0, sram_di=0.
- Response register, set at the grant edge:
  - resp_port: NONE/IM/DM.
  - resp_rd: 1 if read.
- Next cycle:
  - sram_oe = resp_rd.
  - Port matching resp_port raises its rvalid for 1 cycle. Writes also raise dm_rvalid, with dm_rdata = 0.
  - Read data is sram_do passed through combinationally. The non-selected rdata reads 0.
- starve_cnt (4 bits):
  - Increments on cycles with im_req & ~im_gnt, saturating at STARVE_LIMIT.
  - Clears on im_gnt or when im_req is low.
- Requesters hold req/addr/wdata until gnt. Deasserting req before gnt is legal and causes no access.
- dm_web partial (e.g. 4'b1100) writes only bytes whose bit is 0; macro handles masking.

## Timing
- Grant: same cycle as request (0-cycle decision). Read latency: 1 cycle, rvalid in cycle N+1 for grant in cycle N.
- Back-to-back grants: one per cycle, full throughput. Responses of consecutive grants appear on consecutive cycles, each tagged correctly.
- Simultaneous im_req & dm_req, starve_cnt < STARVE_LIMIT: dm granted, im stalls, starve_cnt +1.
- Continuous dm_req plus im_req: im is granted every STARVE_LIMIT+1 cycles. Default: 4 dm grants, then 1 im grant.
- Reset values:
  - Combinational outputs, with requests low: im_gnt=0, dm_gnt=0, sram_cs=0, sram_web=all ones, sram_a=0, sram_di=0.
  - Registered: im_rvalid=0, dm_rvalid=0, sram_oe=0, im_rdata=0, dm_rdata=0, resp_port=NONE, starve_cnt=0.
- While rst is high, grants are suppressed: im_gnt=dm_gnt=sram_cs=0 regardless of requests.
- Reset asserted mid-transaction: the pending response is discarded, with no rvalid after reset release. The first grant is possible in the first cycle with rst low.

## Structure
- Shared package mem_arb_pkg: typedef enum logic [1:0] resp_port_e {RESP_NONE, RESP_IM, RESP_DM}; localparam WEB_READ = '1.
- Single module; no sub-module needed. Priority logic is a small always_comb block; response/starvation logic is one always_ff block with async reset.

## Test plan
- Reset, then im_req=1, im_addr=14'h0010, SRAM word 'h0010 = 32'h00000013 → im_gnt=1 same cycle; next cycle im_rvalid=1, im_rdata=32'h00000013, sram_oe=1, dm_rvalid=0.
- dm_req=1, dm_web=4'b1100, dm_addr=14'h2000, dm_wdata=32'hAABBCCDD, prior word 32'h11223344 → sram_web=4'b1100; dm_rvalid=1 next cycle with dm_rdata=0; readback gives 32'h1122CCDD.
- im_req and dm_req both held high 10 cycles, STARVE_LIMIT=4 → grant sequence DM,DM,DM,DM,IM,DM,DM,DM,DM,IM. Each rvalid follows its grant by 1 cycle on the correct port.
- Write sequence dm_addr=14'h3fff, dm_wdata=32'hFFFFFFFF (SIM_END) interleaved with continuous fetch → word 'h3fff reads 32'hFFFFFFFF; no fetch rvalid is lost or duplicated (count grants == count rvalids per port).
- rst pulsed in the cycle after a dm read grant → dm_rvalid stays 0; sram_oe=0; starve_cnt=0. After release, im_req gets granted in the first cycle.
- im_req dropped after 2 denied cycles, then re-raised with dm_req continuously high → starve_cnt restarted from 0; im granted only after 4 further denied cycles.
